// File: rtl/mem_share_pkg.sv
// Shared definitions for the two-port shared register array arbiter:
// owner state encoding and the reset contents of the array.
package mem_share_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    localparam logic [7:0] INIT0 = 8'h07;
    localparam logic [7:0] INIT1 = 8'h05;

endpackage

// File: rtl/mem_share_arb_if.sv
// Request/grant/read-return bundle for both requesters of mem_share_arb.
// master = the requesters' side, slave = the arbiter.
interface mem_share_arb_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             req0;
    logic             we0;
    logic [AW-1:0]    addr0;
    logic [WIDTH-1:0] wdata0;
    logic             gnt0;
    logic             rvalid0;
    logic [WIDTH-1:0] rdata0;

    logic             req1;
    logic             we1;
    logic [AW-1:0]    addr1;
    logic [WIDTH-1:0] wdata1;
    logic             gnt1;
    logic             rvalid1;
    logic [WIDTH-1:0] rdata1;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1
    );
endinterface

// File: rtl/share_regfile.sv
// DEPTH x WIDTH register array with one write port and one registered read
// port. Synchronous reset restores the init contents (entry0/entry1 from the
// package, the rest zero); a write presented in a reset cycle is dropped.
module share_regfile
    import mem_share_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Array storage: reset to init contents, otherwise commit the write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == 0) begin
                    mem_q[i] <= WIDTH'(INIT0);
                end else if (i == 1) begin
                    mem_q[i] <= WIDTH'(INIT1);
                end else begin
                    mem_q[i] <= {WIDTH{1'b0}};
                end
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read: captures the pre-write value, holds when not reading.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= {WIDTH{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_share_arb.sv
// Round-robin arbiter sharing one register array between two requesters.
// One access per cycle; the owner may keep the grant for up to MAX_BURST
// beats while the other port waits, then must yield.
module mem_share_arb
    import mem_share_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = 2,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_share_arb_if.slave bus
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    owner_e           owner_q, owner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic [WIDTH-1:0] rhold0_q, rhold1_q;

    logic             gnt0_s, gnt1_s;
    logic             we_s, re_s;
    logic [AW-1:0]    addr_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] rd_data_s;

    // Grant decision; no grant is issued while reset is held.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (bus.req0 && bus.req1) begin
            case (owner_q)
                OWN_P0: begin
                    gnt0_s = (cnt_q < CNT_LAST);
                    gnt1_s = !(cnt_q < CNT_LAST);
                end
                OWN_P1: begin
                    gnt1_s = (cnt_q < CNT_LAST);
                    gnt0_s = !(cnt_q < CNT_LAST);
                end
                default: begin
                    gnt0_s = last_q;
                    gnt1_s = !last_q;
                end
            endcase
        end else if (bus.req0) begin
            gnt0_s = 1'b1;
        end else if (bus.req1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Owner / burst counter / tie-break next state and read-valid strobes.
    always_comb begin
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        rvalid0_d = gnt0_s && !bus.we0;
        rvalid1_d = gnt1_s && !bus.we1;
        if (gnt0_s) begin
            owner_d = OWN_P0;
            last_d  = 1'b0;
            if (owner_q != OWN_P0) begin
                cnt_d = {CW{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (gnt1_s) begin
            owner_d = OWN_P1;
            last_d  = 1'b1;
            if (owner_q != OWN_P1) begin
                cnt_d = {CW{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            owner_d = OWN_NONE;
            cnt_d   = {CW{1'b0}};
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q   <= OWN_NONE;
            cnt_q     <= {CW{1'b0}};
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // Per-port read data hold so each port keeps its last returned word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rhold0_q <= {WIDTH{1'b0}};
            rhold1_q <= {WIDTH{1'b0}};
        end else begin
            if (rvalid0_q) begin
                rhold0_q <= rd_data_s;
            end
            if (rvalid1_q) begin
                rhold1_q <= rd_data_s;
            end
        end
    end

    // Steer the granted port's access onto the single array port.
    always_comb begin
        we_s    = 1'b0;
        re_s    = 1'b0;
        addr_s  = bus.addr0;
        wdata_s = bus.wdata0;
        if (gnt1_s) begin
            we_s    = bus.we1;
            re_s    = !bus.we1;
            addr_s  = bus.addr1;
            wdata_s = bus.wdata1;
        end else if (gnt0_s) begin
            we_s    = bus.we0;
            re_s    = !bus.we0;
            addr_s  = bus.addr0;
            wdata_s = bus.wdata0;
        end else begin
            we_s = 1'b0;
            re_s = 1'b0;
        end
    end

    share_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we_s),
        .waddr_i (addr_s),
        .wdata_i (wdata_s),
        .re_i    (re_s),
        .raddr_i (addr_s),
        .rdata_o (rd_data_s)
    );

    assign bus.gnt0    = gnt0_s;
    assign bus.gnt1    = gnt1_s;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rvalid0_q ? rd_data_s : rhold0_q;
    assign bus.rdata1  = rvalid1_q ? rd_data_s : rhold1_q;

endmodule

// File: tb/tb_mem_share_arb.sv
// Testbench for mem_share_arb: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of grants and the array.
module tb_mem_share_arb;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 4;
    localparam int AW        = 2;
    localparam int MAX_BURST = 4;

    logic clk;
    logic rst_n;

    mem_share_arb_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    mem_share_arb #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: owner (-1 none), length of current run of grants
    // to that owner, port granted most recently, array contents, read returns.
    int         m_owner;
    int         m_run;
    int         m_last;
    logic [7:0] m_mem [DEPTH];
    logic       m_rv [2];
    logic [7:0] m_rd [2];

    int n_checks;
    int n_pass;

    // Pending transaction per port (held until granted).
    logic       p_req [2];
    logic       p_we  [2];
    logic [1:0] p_addr[2];
    logic [7:0] p_data[2];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_mem[0] = 8'h07;
        m_mem[1] = 8'h05;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        m_rd[0] = 8'h00; m_rd[1] = 8'h00;
    endtask

    // One clock cycle: drive inputs, check grants, clock, check read returns.
    task automatic step(input logic rs,
                        input logic r0, input logic w0, input logic [1:0] a0, input logic [7:0] d0,
                        input logic r1, input logic w1, input logic [1:0] a1, input logic [7:0] d1,
                        output int g);
        logic       wr;
        logic [1:0] ad;
        logic [7:0] dd;
        @(negedge clk);
        rst_n = rs;
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        #1;
        g = -1;
        if (rs) begin
            if (r0 && r1) begin
                if (m_owner < 0)           g = 1 - m_last;
                else if (m_run < MAX_BURST) g = m_owner;
                else                        g = 1 - m_owner;
            end else if (r0) begin
                g = 0;
            end else if (r1) begin
                g = 1;
            end
        end
        check("gnt0", {7'd0, bus.gnt0}, {7'd0, g == 0});
        check("gnt1", {7'd0, bus.gnt1}, {7'd0, g == 1});
        @(posedge clk);
        if (!rs) begin
            model_reset();
        end else begin
            m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            if (g >= 0) begin
                if (g == m_owner) m_run++;
                else begin m_owner = g; m_run = 1; end
                m_last = g;
                wr = (g == 0) ? w0 : w1;
                ad = (g == 0) ? a0 : a1;
                dd = (g == 0) ? d0 : d1;
                if (wr) m_mem[ad] = dd;
                else begin m_rv[g] = 1'b1; m_rd[g] = m_mem[ad]; end
            end else begin
                m_owner = -1;
                m_run   = 0;
            end
        end
        #1;
        check("rvalid0", {7'd0, bus.rvalid0}, {7'd0, m_rv[0]});
        check("rvalid1", {7'd0, bus.rvalid1}, {7'd0, m_rv[1]});
        check("rdata0", bus.rdata0, m_rd[0]);
        check("rdata1", bus.rdata1, m_rd[1]);
    endtask

    // Keep presenting pending transactions until both ports are served.
    task automatic serve();
        int g;
        int budget;
        budget = 0;
        while ((p_req[0] || p_req[1]) && budget < 20) begin
            step(1'b1, p_req[0], p_we[0], p_addr[0], p_data[0],
                       p_req[1], p_we[1], p_addr[1], p_data[1], g);
            if (g >= 0) p_req[g] = 1'b0;
            budget++;
        end
        if (p_req[0] || p_req[1]) begin
            n_checks++;
            $error("FAIL serve_timeout observed=pending expected=served");
            p_req[0] = 1'b0; p_req[1] = 1'b0;
        end
    endtask

    initial begin
        int g;
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 2'd0; bus.wdata0 = 8'h00;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 2'd0; bus.wdata1 = 8'h00;
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        model_reset();

        // Reset and reset-state outputs.
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, g);
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, g);

        // Init contents: read0 addr0, read1 addr1, then the zero entries.
        step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, g);
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd1, 8'h00, g);
        step(1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, g);
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd3, 8'h00, g);
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, g);

        // Both reads held from idle: port 0 first, then 4/4 alternation.
        for (int i = 0; i < 17; i++)
            step(1'b1, 1'b1, 1'b0, 2'(i), 8'h00, 1'b1, 1'b0, 2'(i + 1), 8'h00, g);
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, g);

        // Port 0 writes A5 to addr3 while port 1 reads addr3, then re-read.
        p_req[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 2'd3; p_data[0] = 8'hA5;
        p_req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 2'd3; p_data[1] = 8'h00;
        serve();
        p_req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 2'd3; p_data[1] = 8'h00;
        serve();
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, g);

        // Only port 1 for 10 cycles, then port 0 joins (counter saturated).
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'(i), 8'h00, g);
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b0, 2'(i), 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, g);
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, g);

        // Port 1 write burst, reset lands on a write to entry1 (dropped).
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd2, 8'h3C, g);
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd3, 8'h5A, g);
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd1, 8'hEE, g);
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, g);
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd1, 8'h00, g);
        step(1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, g);

        // Randomized traffic; requests hold until granted.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!p_req[k] && ($urandom_range(0, 3) != 0)) begin
                    p_req[k]  = 1'b1;
                    p_we[k]   = 1'($urandom_range(0, 1));
                    p_addr[k] = 2'($urandom_range(0, 3));
                    p_data[k] = 8'($urandom_range(0, 255));
                end
            end
            step(1'b1, p_req[0], p_we[0], p_addr[0], p_data[0],
                       p_req[1], p_we[1], p_addr[1], p_data[1], g);
            if (g >= 0) p_req[g] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
